// File: rtl/bandai_mapper_pkg.sv
// Shared types and constants for the Bandai-style cartridge mapper.
// MAPPER_WIDE_BANK_EN selects 16-bit bank registers and data bus.
package bandai_mapper_pkg;

  typedef enum logic [1:0] {
    ST_ARMED,
    ST_SHIFT,
    ST_DONE
  } unlock_state_t;

  localparam int CTRL_REARM_BIT = 0;
  localparam int CTRL_BUSY_BIT  = 6;
  localparam int CTRL_ARMED_BIT = 7;

  localparam logic [7:0] HI_PORT_OFFSET = 8'h10;

  localparam int DEF_SEQ_LEN = 18;
  localparam logic [DEF_SEQ_LEN-1:0] DEF_SEQ_PAT = 18'h05140;

`ifdef MAPPER_WIDE_BANK_EN
  localparam int DQ_W = 16;
`else
  localparam int DQ_W = 8;
`endif

  typedef struct packed {
    logic       hit;
    logic       ctrl;
    logic       hi;
    logic [3:0] idx;
  } port_dec_t;

endpackage

// File: rtl/bandai_mapper_gen_unlock.sv
// Unlock bit-stream generator: waits armed, streams the pattern LSB first,
// then idles high until re-armed from the mapper's control register.
module unlock_seq_gen
  import bandai_mapper_pkg::*;
#(
  parameter int                   SEQ_LEN = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0]   SEQ_PAT = DEF_SEQ_PAT
) (
  input  logic CLK,
  input  logic RST,
  input  logic trigger,
  input  logic rearm,
  output logic SO,
  output logic ARMED,
  output logic busy
);

  localparam int CNT_W = $clog2(SEQ_LEN + 1);

  unlock_state_t      state, state_nxt;
  logic [SEQ_LEN-1:0] sreg, sreg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               so_q, so_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_ARMED;
      sreg  <= '1;
      cnt   <= '0;
      so_q  <= 1'b1;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      so_q  <= so_nxt;
    end
  end

  // SO is registered, so bit 0 leaves on the very edge that samples the trigger.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    so_nxt    = so_q;
    case (state)
      ST_ARMED: begin
        if (trigger) begin
          so_nxt    = SEQ_PAT[0];
          sreg_nxt  = {1'b1, SEQ_PAT[SEQ_LEN-1:1]};
          cnt_nxt   = CNT_W'(1);
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(SEQ_LEN)) begin
          so_nxt    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          so_nxt   = sreg[0];
          sreg_nxt = {1'b1, sreg[SEQ_LEN-1:1]};
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        so_nxt = 1'b1;
        if (rearm) state_nxt = ST_ARMED;
      end
      default: state_nxt = ST_ARMED;
    endcase
  end

  assign SO    = so_q;
  assign ARMED = (state == ST_ARMED);
  assign busy  = (state == ST_SHIFT);

endmodule

// File: rtl/bandai_mapper_gen.sv
// Cartridge mapper top: WEn synchroniser, write capture, bank file, decode.
// MAPPER_WIDE_BANK_EN adds 16-bit banks with separately addressed high bytes.
module bandai_mapper_gen
  import bandai_mapper_pkg::*;
#(
  parameter int                 NBANK       = 4,
  parameter int                 RADDR_W     = 7,
  parameter logic [7:0]         BASE_PORT   = 8'hC0,
  parameter logic [7:0]         UNLOCK_PORT = 8'hA5,
  parameter int                 SEQ_LEN     = DEF_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ_PAT     = DEF_SEQ_PAT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CEn,
  input  logic               SSn,
  input  logic               WEn,
  input  logic               OEn,
  input  logic [7:0]         ADDR,
  input  logic [3:0]         SEG,
  input  logic [DQ_W-1:0]    DQ_I,
  output logic [DQ_W-1:0]    DQ_O,
  output logic               DQ_OE,
  output logic               SO,
  output logic               SO_OE,
  output logic               ROMCEn,
  output logic               RAMCEn,
  output logic [RADDR_W-1:0] RADDR,
  output logic               ARMED
);

  localparam int IDXW = (NBANK > 1) ? $clog2(NBANK) : 1;

  logic [DQ_W-1:0] bank [NBANK];
  logic            we_s1, we_s2, we_s3;
  logic            cap_valid;
  logic [7:0]      cap_addr;
  logic [DQ_W-1:0] cap_data;
  logic            io_cyc, mem_cyc, commit, rearm, trigger, busy;
  port_dec_t       cap_dec, rd_dec;

  function automatic port_dec_t decode_port(input logic [7:0] a);
    port_dec_t d;
    int        off;
    d   = '0;
    off = int'(a) - int'(BASE_PORT);
    if (off >= 0 && off < NBANK) begin
      d.hit = 1'b1;
      d.idx = 4'(off);
    end else if (off == NBANK) begin
      d.hit  = 1'b1;
      d.ctrl = 1'b1;
    end
`ifdef MAPPER_WIDE_BANK_EN
    else if (off >= int'(HI_PORT_OFFSET) && off < int'(HI_PORT_OFFSET) + NBANK) begin
      d.hit = 1'b1;
      d.hi  = 1'b1;
      d.idx = 4'(off - int'(HI_PORT_OFFSET));
    end
`endif
    return d;
  endfunction

  assign io_cyc  = ~SSn & CEn;
  assign mem_cyc = SSn & ~CEn;
  assign cap_dec = decode_port(cap_addr);
  assign rd_dec  = decode_port(ADDR);
  assign commit  = we_s2 & ~we_s3 & cap_valid;
  assign rearm   = commit & cap_dec.ctrl & cap_data[CTRL_REARM_BIT];
  assign trigger = io_cyc & (ADDR == UNLOCK_PORT);

  // Bus and data are re-captured every cycle the synced strobe is low, so the
  // last values before WEn rises are the ones committed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_s1     <= 1'b1;
      we_s2     <= 1'b1;
      we_s3     <= 1'b1;
      cap_valid <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= '0;
    end else begin
      we_s1 <= WEn;
      we_s2 <= we_s1;
      we_s3 <= we_s2;
      if (~we_s2 & io_cyc) begin
        cap_valid <= 1'b1;
        cap_addr  <= ADDR;
        cap_data  <= DQ_I;
      end else if (commit) begin
        cap_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NBANK; i++) bank[i] <= '1;
    end else if (commit & cap_dec.hit & ~cap_dec.ctrl) begin
`ifdef MAPPER_WIDE_BANK_EN
      if (cap_dec.hi) bank[cap_dec.idx[IDXW-1:0]][15:8] <= cap_data[7:0];
      else            bank[cap_dec.idx[IDXW-1:0]][7:0]  <= cap_data[7:0];
`else
      bank[cap_dec.idx[IDXW-1:0]] <= cap_data;
`endif
    end
  end

  unlock_seq_gen #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ_PAT (SEQ_PAT)
  ) u_unlock (
    .CLK     (CLK),
    .RST     (RST),
    .trigger (trigger),
    .rearm   (rearm),
    .SO      (SO),
    .ARMED   (ARMED),
    .busy    (busy)
  );

  assign SO_OE  = ~RST;
  assign ROMCEn = ~(mem_cyc & (SEG >= 4'd2));
  assign RAMCEn = ~(mem_cyc & (SEG == 4'd1));
  assign DQ_OE  = io_cyc & rd_dec.hit & ~OEn & WEn;

  // Segments beyond the bank file fold bank 0 into the upper address bits.
  always_comb begin
    RADDR = '0;
    if (mem_cyc && SEG != 4'd0) begin
      if (int'(SEG) < NBANK) RADDR = bank[SEG[IDXW-1:0]][RADDR_W-1:0];
      else                   RADDR = {bank[0][RADDR_W-5:0], SEG};
    end
  end

  always_comb begin
    DQ_O = '0;
    if (DQ_OE) begin
      if (rd_dec.ctrl) begin
        DQ_O[CTRL_ARMED_BIT] = ARMED;
        DQ_O[CTRL_BUSY_BIT]  = busy;
      end else begin
`ifdef MAPPER_WIDE_BANK_EN
        if (rd_dec.hi) DQ_O = {8'h00, bank[rd_dec.idx[IDXW-1:0]][15:8]};
        else           DQ_O = {8'h00, bank[rd_dec.idx[IDXW-1:0]][7:0]};
`else
        DQ_O = bank[rd_dec.idx[IDXW-1:0]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_bandai_mapper_gen.sv
// Directed self-checking bench for bandai_mapper_gen in its default build.
module tb_bandai_mapper_gen;
  import bandai_mapper_pkg::*;

  logic            CLK = 1'b0;
  logic            RST;
  logic            CEn, SSn, WEn, OEn;
  logic [7:0]      ADDR;
  logic [3:0]      SEG;
  logic [DQ_W-1:0] DQ_I;
  logic [DQ_W-1:0] DQ_O;
  logic            DQ_OE, SO, SO_OE, ROMCEn, RAMCEn, ARMED;
  logic [6:0]      RADDR;

  int check_count = 0;
  int error_count = 0;
  int exp_stream [18] = '{0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0};

  always #5 CLK = ~CLK;

  bandai_mapper_gen dut (
    .CLK    (CLK),
    .RST    (RST),
    .CEn    (CEn),
    .SSn    (SSn),
    .WEn    (WEn),
    .OEn    (OEn),
    .ADDR   (ADDR),
    .SEG    (SEG),
    .DQ_I   (DQ_I),
    .DQ_O   (DQ_O),
    .DQ_OE  (DQ_OE),
    .SO     (SO),
    .SO_OE  (SO_OE),
    .ROMCEn (ROMCEn),
    .RAMCEn (RAMCEn),
    .RADDR  (RADDR),
    .ARMED  (ARMED)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic ssn, input logic cen, input logic wen, input logic oen,
                               input logic [7:0] addr, input logic [3:0] seg, input logic [7:0] data);
    SSn  = ssn;
    CEn  = cen;
    WEn  = wen;
    OEn  = oen;
    ADDR = addr;
    SEG  = seg;
    DQ_I = DQ_W'(data);
    #1;
  endtask

  task automatic busIdle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 4'h0, 8'h00);
  endtask

  task automatic ioWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, addr, 4'h0, data);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, addr, 4'h0, data);
    repeat (2) tick();
    busIdle();
    tick();
  endtask

  task automatic triggerUnlock();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 4'h0, 8'h00);
    tick();
    busIdle();
  endtask

  task automatic checkStream();
    for (int k = 0; k < 18; k++) begin
      checkOutput($sformatf("so_bit%0d", k), 32'(SO), 32'(exp_stream[k]));
      if (k == 0) checkOutput("armed_in_shift", 32'(ARMED), 32'd0);
      if (k == 3) begin
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC4, 4'h0, 8'h00);
        checkOutput("ctrl_read_busy", 32'(DQ_O), 32'h40);
        busIdle();
      end
      tick();
    end
    checkOutput("so_after_stream", 32'(SO), 32'd1);
    checkOutput("armed_after_stream", 32'(ARMED), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    busIdle();
    tick();
    tick();
    checkOutput("so_oe_in_reset", 32'(SO_OE), 32'd0);
    checkOutput("so_in_reset", 32'(SO), 32'd1);
    checkOutput("armed_in_reset", 32'(ARMED), 32'd1);
    RST = 1'b0;
    #1;
    checkOutput("so_oe_after_reset", 32'(SO_OE), 32'd1);

    // Memory map after reset
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h2, 8'h00);
    checkOutput("romcen_seg2", 32'(ROMCEn), 32'd0);
    checkOutput("ramcen_seg2", 32'(RAMCEn), 32'd1);
    checkOutput("raddr_seg2_reset", 32'(RADDR), 32'h7F);
    checkOutput("so_idle", 32'(SO), 32'd1);
    checkOutput("armed_idle", 32'(ARMED), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h0, 8'h00);
    checkOutput("romcen_seg0", 32'(ROMCEn), 32'd1);
    checkOutput("ramcen_seg0", 32'(RAMCEn), 32'd1);
    checkOutput("raddr_seg0", 32'(RADDR), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h1, 8'h00);
    checkOutput("ramcen_seg1", 32'(RAMCEn), 32'd0);
    checkOutput("romcen_seg1", 32'(ROMCEn), 32'd1);
    checkOutput("raddr_seg1_reset", 32'(RADDR), 32'h7F);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 4'h2, 8'h00);
    checkOutput("romcen_both_sel", 32'(ROMCEn), 32'd1);
    checkOutput("raddr_both_sel", 32'(RADDR), 32'h00);

    // Bank write latency
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hC2, 4'h0, 8'h12);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hC2, 4'h0, 8'h12);
    repeat (2) tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h2, 8'h00);
    checkOutput("raddr_before_commit", 32'(RADDR), 32'h7F);
    tick();
    checkOutput("raddr_after_commit", 32'(RADDR), 32'h12);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h5, 8'h00);
    checkOutput("raddr_seg5", 32'(RADDR), 32'h75);
    checkOutput("romcen_seg5", 32'(ROMCEn), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h4, 8'h00);
    checkOutput("raddr_seg4", 32'(RADDR), 32'h74);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h3, 8'h00);
    checkOutput("raddr_seg3", 32'(RADDR), 32'h7F);
    busIdle();

    // Non-hit ports, including the high-byte window, must not write
    ioWrite(8'hB0, 8'h00);
    ioWrite(8'hD2, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h2, 8'h00);
    checkOutput("raddr_nonhit_write", 32'(RADDR), 32'h12);
    busIdle();

    // Register reads
    ioWrite(8'hC1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC1, 4'h0, 8'h00);
    checkOutput("dq_oe_c1", 32'(DQ_OE), 32'd1);
    checkOutput("dq_o_c1", 32'(DQ_O), 32'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC2, 4'h0, 8'h00);
    checkOutput("dq_o_c2", 32'(DQ_O), 32'h12);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC4, 4'h0, 8'h00);
    checkOutput("dq_o_ctrl_armed", 32'(DQ_O), 32'h80);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hB0, 4'h0, 8'h00);
    checkOutput("dq_oe_b0", 32'(DQ_OE), 32'd0);
    checkOutput("dq_o_b0", 32'(DQ_O), 32'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'hC1, 4'h0, 8'h00);
    checkOutput("dq_oe_we_low", 32'(DQ_OE), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC1, 4'h1, 8'h00);
    checkOutput("dq_oe_mem_cycle", 32'(DQ_OE), 32'd0);
    checkOutput("raddr_seg1_written", 32'(RADDR), 32'h3C);
    busIdle();

    // Unlock stream and ignored re-trigger
    triggerUnlock();
    checkStream();
    triggerUnlock();
    for (int k = 0; k < 4; k++) begin
      checkOutput("so_retrigger_done", 32'(SO), 32'd1);
      tick();
    end
    checkOutput("armed_retrigger_done", 32'(ARMED), 32'd0);

    // Re-arm only via CTRL bit0 in DONE
    ioWrite(8'hC4, 8'hFE);
    checkOutput("armed_ctrl_fe", 32'(ARMED), 32'd0);
    ioWrite(8'hC4, 8'h01);
    checkOutput("armed_ctrl_01", 32'(ARMED), 32'd1);
    triggerUnlock();
    checkStream();

    ioWrite(8'hC4, 8'h01);
    triggerUnlock();
    ioWrite(8'hC4, 8'h01);
    repeat (14) tick();
    checkOutput("armed_rearm_in_shift", 32'(ARMED), 32'd0);
    checkOutput("so_rearm_in_shift", 32'(SO), 32'd1);

    // Reset in mid-stream
    ioWrite(8'hC4, 8'h01);
    triggerUnlock();
    repeat (7) tick();
    checkOutput("so_bit7_before_rst", 32'(SO), 32'd0);
    RST = 1'b1;
    #1;
    checkOutput("so_oe_mid_rst", 32'(SO_OE), 32'd0);
    checkOutput("so_mid_rst", 32'(SO), 32'd1);
    checkOutput("armed_mid_rst", 32'(ARMED), 32'd1);
    tick();
    RST = 1'b0;
    #1;
    checkOutput("so_oe_post_rst", 32'(SO_OE), 32'd1);
    tick();
    checkOutput("so_post_rst", 32'(SO), 32'd1);
    checkOutput("armed_post_rst", 32'(ARMED), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h2, 8'h00);
    checkOutput("raddr_seg2_post_rst", 32'(RADDR), 32'h7F);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 4'h1, 8'h00);
    checkOutput("raddr_seg1_post_rst", 32'(RADDR), 32'h7F);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC2, 4'h0, 8'h00);
    checkOutput("dq_o_c2_post_rst", 32'(DQ_O), 32'hFF);
    busIdle();

    // A captured but uncommitted write is dropped by reset
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 4'h0, 8'h55);
    repeat (3) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'hC3, 4'h0, 8'h55);
    tick();
    RST = 1'b1;
    #1;
    RST = 1'b0;
    #1;
    busIdle();
    repeat (4) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 4'h0, 8'h00);
    checkOutput("dq_o_c3_discarded", 32'(DQ_O), 32'hFF);
    busIdle();

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
